// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer and its debug/status readout:
// state encodings, status field widths and small elaboration-time helpers.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 3;
  localparam int LOST_W  = 8;

  // Sequencer states. Encodings 5..7 are unused and recover to ST_RESET.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  // Larger of two cycle parameters, used to size the shared counter.
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold (maxCycles - 1); never narrower than one bit.
  function automatic int cntWidth(input int maxCycles);
    return (maxCycles > 1) ? $clog2(maxCycles) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level input.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / recovery sequencer running entirely on the reference clock.
// Holds the PLL in reset, waits for lock, qualifies lock stability, then
// releases the core reset. Filtered loss of lock in RUN re-sequences the PLL;
// repeated lock timeouts end in FAIL until a soft reset or hard reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int LOCK_STABLE_CYCLES  = 4096,
  parameter int LOSS_FILTER_CYCLES  = 8,
  parameter int MAX_RETRIES         = 7
) (
  input  logic               i_refclk,
  input  logic               i_rst,
  input  logic               i_pll_locked,
  input  logic               i_soft_reset,
  output logic               o_pll_rst,
  output logic               o_core_rst,
  output logic               o_ready,
  output logic               o_fail,
  output logic [STATE_W-1:0] o_state,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic [LOST_W-1:0]  o_lock_lost_cnt
);

  // The single down-counter is sized for the longest interval it ever times.
  localparam int MAX_CYCLES = maxOf(maxOf(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                    maxOf(LOCK_STABLE_CYCLES, LOSS_FILTER_CYCLES));
  localparam int CNT_W      = cntWidth(MAX_CYCLES);

  // Each interval of N cycles is timed by loading N-1 and leaving the state
  // on the cycle the counter is already at zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LOAD  = CNT_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
  localparam logic [LOST_W-1:0]  LOST_MAX    = '1;
  localparam logic [LOST_W-1:0]  LOST_ONE    = LOST_W'(1);

  logic               w_lk;
  seq_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retryCnt;
  logic [LOST_W-1:0]  r_lockLostCnt;
  logic               r_pllRst;
  logic               r_coreRst;
  logic               r_ready;
  logic               r_fail;

  seq_state_e         w_nextState;
  logic [CNT_W-1:0]   w_nextCnt;
  logic [RETRY_W-1:0] w_nextRetry;
  logic [LOST_W-1:0]  w_nextLost;

  // pll_locked comes from the PLL's own domain; only the synchronized copy is used.
  sync_2ff u_lockSync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lk)
  );

  // Next-state, shared-counter and status-counter decode; soft reset overrides everything.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextRetry = r_retryCnt;
    w_nextLost  = r_lockLostCnt;

    if (i_soft_reset) begin
      w_nextState = ST_RESET;
      w_nextCnt   = HOLD_LOAD;
      w_nextRetry = '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_cnt == '0) begin
            w_nextState = ST_WAIT_LOCK;
            w_nextCnt   = TIMEOUT_LOAD;
          end else begin
            w_nextCnt = r_cnt - CNT_ONE;
          end
        end

        ST_WAIT_LOCK: begin
          if (w_lk) begin
            w_nextState = ST_STABLE;
            w_nextCnt   = STABLE_LOAD;
          end else if (r_cnt == '0) begin
            if (r_retryCnt == RETRY_LIMIT) begin
              w_nextState = ST_FAIL;
              w_nextCnt   = '0;
            end else begin
              w_nextState = ST_RESET;
              w_nextCnt   = HOLD_LOAD;
              w_nextRetry = r_retryCnt + RETRY_ONE;
            end
          end else begin
            w_nextCnt = r_cnt - CNT_ONE;
          end
        end

        // A single unlocked cycle sends us back to waiting without costing a retry.
        ST_STABLE: begin
          if (!w_lk) begin
            w_nextState = ST_WAIT_LOCK;
            w_nextCnt   = TIMEOUT_LOAD;
          end else if (r_cnt == '0) begin
            w_nextState = ST_RUN;
            w_nextCnt   = FILTER_LOAD;
            w_nextRetry = '0;
          end else begin
            w_nextCnt = r_cnt - CNT_ONE;
          end
        end

        // In RUN the counter acts as the loss filter: any locked cycle re-arms it.
        ST_RUN: begin
          if (w_lk) begin
            w_nextCnt = FILTER_LOAD;
          end else if (r_cnt == '0) begin
            w_nextState = ST_RESET;
            w_nextCnt   = HOLD_LOAD;
            if (r_lockLostCnt != LOST_MAX) begin
              w_nextLost = r_lockLostCnt + LOST_ONE;
            end
          end else begin
            w_nextCnt = r_cnt - CNT_ONE;
          end
        end

        ST_FAIL: begin
          w_nextCnt = '0;
        end

        default: begin
          w_nextState = ST_RESET;
          w_nextCnt   = HOLD_LOAD;
        end
      endcase
    end
  end

  // State, counters and outputs all register together; outputs are decoded from the
  // next state so pll_rst and core_rst move on the same edge as the state change.
  // Hard reset looks exactly like a fresh entry into RESET, hold count included.
  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RESET;
      r_cnt         <= HOLD_LOAD;
      r_retryCnt    <= '0;
      r_lockLostCnt <= '0;
      r_pllRst      <= 1'b1;
      r_coreRst     <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_cnt         <= w_nextCnt;
      r_retryCnt    <= w_nextRetry;
      r_lockLostCnt <= w_nextLost;
      r_pllRst      <= (w_nextState == ST_RESET) || (w_nextState == ST_FAIL);
      r_coreRst     <= (w_nextState != ST_RUN);
      r_ready       <= (w_nextState == ST_RUN);
      r_fail        <= (w_nextState == ST_FAIL);
    end
  end

  assign o_pll_rst       = r_pllRst;
  assign o_core_rst      = r_coreRst;
  assign o_ready         = r_ready;
  assign o_fail          = r_fail;
  assign o_state         = r_state;
  assign o_retry_cnt     = r_retryCnt;
  assign o_lock_lost_cnt = r_lockLostCnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short cycle parameters.
// Expected values are queued when stimulus is applied and popped against the
// DUT outputs once the corresponding behaviour is due.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 8;
  localparam int FILTER  = 3;
  localparam int RETRIES = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       softReset;
  logic       oPllRst;
  logic       oCoreRst;
  logic       oReady;
  logic       oFail;
  logic [2:0] oState;
  logic [2:0] oRetryCnt;
  logic [7:0] oLockLostCnt;

  int compCount = 0;
  int failCount = 0;

  typedef struct {
    string tag;
    int    value;
  } expItem_t;

  expItem_t expQ[$];

  always #5 clock = ~clock;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOSS_FILTER_CYCLES  (FILTER),
    .MAX_RETRIES         (RETRIES)
  ) dut (
    .i_refclk        (clock),
    .i_rst           (reset),
    .i_pll_locked    (locked),
    .i_soft_reset    (softReset),
    .o_pll_rst       (oPllRst),
    .o_core_rst      (oCoreRst),
    .o_ready         (oReady),
    .o_fail          (oFail),
    .o_state         (oState),
    .o_retry_cnt     (oRetryCnt),
    .o_lock_lost_cnt (oLockLostCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic expectValue(input string tag, input int value);
    expItem_t item;
    item.tag   = tag;
    item.value = value;
    expQ.push_back(item);
  endtask

  task automatic scoreOutput(input logic [31:0] actual);
    expItem_t item;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_underflow", actual, 32'hFFFF_FFFF);
    end else begin
      item = expQ.pop_front();
      checkOutput(item.tag, actual, item.value);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic lockedVal, input logic softVal);
    locked    = lockedVal;
    softReset = softVal;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (oState !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Hard stop in case something outside the bounded waits stalls the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    int   m;
    logic lowSeen;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();

    // Reset values
    expectValue("rst_state", ST_RESET);
    expectValue("rst_pll_rst", 1);
    expectValue("rst_core_rst", 1);
    expectValue("rst_ready", 0);
    expectValue("rst_fail", 0);
    expectValue("rst_retry", 0);
    expectValue("rst_lost", 0);
    scoreOutput(oState);
    scoreOutput(oPllRst);
    scoreOutput(oCoreRst);
    scoreOutput(oReady);
    scoreOutput(oFail);
    scoreOutput(oRetryCnt);
    scoreOutput(oLockLostCnt);

    // Clean lock: pll_rst held for HOLD cycles, core_rst falls 2+STABLE+1 after locked rises
    $display("[TB] clean lock");
    reset = 1'b0;
    expectValue("clean_pll_rst_hold", HOLD);
    n = 0;
    while (oPllRst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    scoreOutput(n);
    repeat (6) tick();
    applyStimulus(1'b1, 1'b0);
    expectValue("clean_core_rst_release", 2 + STABLE + 1);
    expectValue("clean_ready", 1);
    expectValue("clean_retry", 0);
    expectValue("clean_state", ST_RUN);
    n = 0;
    while (oCoreRst === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    scoreOutput(n);
    scoreOutput(oReady);
    scoreOutput(oRetryCnt);
    scoreOutput(oState);

    // Short glitch in RUN is filtered out
    $display("[TB] RUN glitch");
    applyStimulus(1'b0, 1'b0);
    expectValue("glitch_ready_low_seen", 0);
    expectValue("glitch_lost", 0);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b0);
    lowSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oReady !== 1'b1) lowSeen = 1'b1;
    end
    scoreOutput(lowSeen);
    scoreOutput(oLockLostCnt);

    // Real loss of lock in RUN
    $display("[TB] RUN loss");
    applyStimulus(1'b0, 1'b0);
    expectValue("loss_latency", 2 + FILTER);
    expectValue("loss_core_rst", 1);
    expectValue("loss_pll_rst", 1);
    expectValue("loss_lost", 1);
    repeat (4) tick();
    applyStimulus(1'b1, 1'b0);
    waitState(ST_RESET, 10, m);
    scoreOutput(4 + m);
    scoreOutput(oCoreRst);
    scoreOutput(oPllRst);
    scoreOutput(oLockLostCnt);

    // Soft reset back to RESET, then an unstable lock
    $display("[TB] unstable lock");
    applyStimulus(1'b0, 1'b1);
    expectValue("soft_state", ST_RESET);
    expectValue("soft_retry", 0);
    expectValue("soft_lost_kept", 1);
    tick();
    applyStimulus(1'b0, 1'b0);
    scoreOutput(oState);
    scoreOutput(oRetryCnt);
    scoreOutput(oLockLostCnt);
    expectValue("unstable_wait_entry", ST_WAIT_LOCK);
    waitState(ST_WAIT_LOCK, 20, m);
    scoreOutput(oState);
    applyStimulus(1'b1, 1'b0);
    repeat (5) tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0);
    expectValue("unstable_back_to_wait", ST_WAIT_LOCK);
    expectValue("unstable_restable", ST_STABLE);
    expectValue("unstable_core_rst_release", 2 + STABLE + 1);
    expectValue("unstable_retry", 0);
    n = 0;
    while (oCoreRst === 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 2) scoreOutput(oState);
      if (n == 3) scoreOutput(oState);
    end
    scoreOutput(n);
    scoreOutput(oRetryCnt);

    // Never locks: retries exhaust into FAIL
    $display("[TB] never locks");
    applyStimulus(1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k <= RETRIES; k++) begin
      expectValue("never_attempt_state", ST_WAIT_LOCK);
      expectValue("never_attempt_retry", k);
      waitState(ST_WAIT_LOCK, 40, m);
      scoreOutput(oState);
      scoreOutput(oRetryCnt);
      if (k < RETRIES) waitState(ST_RESET, 40, m);
    end
    expectValue("fail_state", ST_FAIL);
    expectValue("fail_flag", 1);
    expectValue("fail_pll_rst", 1);
    expectValue("fail_core_rst", 1);
    expectValue("fail_ready", 0);
    expectValue("fail_sticky", ST_FAIL);
    waitState(ST_FAIL, 40, m);
    scoreOutput(oState);
    scoreOutput(oFail);
    scoreOutput(oPllRst);
    scoreOutput(oCoreRst);
    scoreOutput(oReady);
    repeat (5) tick();
    scoreOutput(oState);
    applyStimulus(1'b0, 1'b1);
    expectValue("fail_exit_state", ST_RESET);
    expectValue("fail_exit_retry", 0);
    expectValue("fail_exit_flag", 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    scoreOutput(oState);
    scoreOutput(oRetryCnt);
    scoreOutput(oFail);

    // Asynchronous reset in the middle of STABLE
    $display("[TB] async reset mid-STABLE");
    applyStimulus(1'b1, 1'b0);
    expectValue("stable_reached", ST_STABLE);
    waitState(ST_STABLE, 30, m);
    scoreOutput(oState);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    expectValue("arst_state", ST_RESET);
    expectValue("arst_pll_rst", 1);
    expectValue("arst_core_rst", 1);
    expectValue("arst_ready", 0);
    expectValue("arst_lost", 0);
    #1;
    scoreOutput(oState);
    scoreOutput(oPllRst);
    scoreOutput(oCoreRst);
    scoreOutput(oReady);
    scoreOutput(oLockLostCnt);
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;

    // soft_reset lands on the same edge as a WAIT_LOCK timeout
    $display("[TB] soft reset vs timeout");
    expectValue("retry_after_timeout", 1);
    waitState(ST_WAIT_LOCK, 20, m);
    waitState(ST_RESET, 40, m);
    scoreOutput(oRetryCnt);
    waitState(ST_WAIT_LOCK, 20, m);
    repeat (TIMEOUT - 1) tick();
    applyStimulus(1'b0, 1'b1);
    expectValue("soft_wins_state", ST_RESET);
    expectValue("soft_wins_retry", 0);
    tick();
    applyStimulus(1'b0, 1'b0);
    scoreOutput(oState);
    scoreOutput(oRetryCnt);

    // soft_reset while already in RESET restarts the hold count
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1);
    expectValue("hold_restart", 1 + HOLD);
    tick();
    applyStimulus(1'b0, 1'b0);
    waitState(ST_WAIT_LOCK, 20, m);
    scoreOutput(1 + m);

    // Saturation of the loss-of-lock counter
    $display("[TB] loss counter saturation");
    applyStimulus(1'b1, 1'b0);
    waitState(ST_RUN, 60, m);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b0);
      waitState(ST_RESET, 20, m);
      if (m >= 20) checkOutput("sat_reset_timeout", oState, ST_RESET);
      applyStimulus(1'b1, 1'b0);
      waitState(ST_RUN, 40, m);
      if (m >= 40) checkOutput("sat_run_timeout", oState, ST_RUN);
      if (i == 0) begin
        expectValue("sat_first", 1);
        scoreOutput(oLockLostCnt);
      end
      if (i == 254) begin
        expectValue("sat_at_255", 255);
        scoreOutput(oLockLostCnt);
      end
    end
    expectValue("sat_hold", 255);
    scoreOutput(oLockLostCnt);

    $display("End of test - %0d assertions evaluated, %0d failures", compCount, failCount);
    $finish;
  end

endmodule
